// File: rtl/fifo_shift_param.sv
// fifo_shift_param: shift-register FIFO with registered count, full/empty and error pulses.
// Defining FIFO_SHIFT_ALMOST_EN adds a registered almost_full output (count >= DEPTH-AF_MARGIN).
module fifo_shift_param #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AF_MARGIN = 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             write,
   input  logic             delete,
   input  logic [WIDTH-1:0] fifo_in,
   output logic [WIDTH-1:0] fifo_out,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             error,
   output logic             ovf_err,
`ifdef FIFO_SHIFT_ALMOST_EN
   output logic             almost_full,
`endif
   output logic             unf_err
);
   logic [WIDTH-1:0] r_q [DEPTH];
   logic [WIDTH-1:0] r_d [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d, unf_q, unf_d, acc_w, acc_d;

   if (AF_MARGIN < 1 || AF_MARGIN >= DEPTH || DEPTH < 2 || WIDTH < 1) begin : g_param_out_of_range
   end

   // W+D on a full FIFO still shifts; W+D on an empty FIFO accepts only the write
   always_comb begin
      acc_w   = write & (~full | delete);
      acc_d   = delete & ~empty;
      ovf_d   = write & ~delete & full;
      unf_d   = delete & empty;
      count_d = count_q + CW'(acc_w) - CW'(acc_d);
      r_d[0]  = acc_w ? fifo_in : r_q[0];
      for (int k = 1; k < DEPTH; k++) r_d[k] = acc_w ? r_q[k-1] : r_q[k];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) r_q[k] <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         r_q     <= r_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // oldest entry sits at r[count-1]
   always_comb begin
      fifo_out = '0;
      for (int k = 0; k < DEPTH; k++) if (count_q == CW'(k + 1)) fifo_out = r_q[k];
   end

   assign count   = count_q;
   assign empty   = count_q == '0;
   assign full    = count_q == CW'(DEPTH);
   assign ovf_err = ovf_q;
   assign unf_err = unf_q;
   assign error   = ovf_q | unf_q;

`ifdef FIFO_SHIFT_ALMOST_EN
   logic af_q;

   always_ff @(posedge clk) begin
      if (reset) af_q <= 1'b0;
      else af_q <= count_d >= CW'(DEPTH - AF_MARGIN);
   end

   assign almost_full = af_q;
`endif
endmodule

// File: doc/fifo_shift_param.md
# fifo_shift_param

Parametrised shift-register FIFO for sample buffering between systolic FFT stages: a chain of WIDTH-bit stage registers that all shift on every accepted write, with a combinational read mux selecting the oldest entry. It extends the fixed 8-bit, 4-deep FIFO with:
- configurable width and depth;
- a registered occupancy count;
- full and empty flags;
- legal simultaneous write+delete;
- a registered, flagged error output.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 4, number of entries (>=2)
- AF_MARGIN, 1, almost-full margin, used only with FIFO_SHIFT_ALMOST_EN (1..DEPTH-1)
- CW (localparam), $clog2(DEPTH+1), count width
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  reset; synchronous and active-high
- write  input  1  push request; fifo_in is sampled at the edge
- delete  input  1  pop request; the oldest entry is discarded at the edge
- fifo_in  input  WIDTH  write data
- fifo_out  output  WIDTH  oldest entry, combinational from the registers; 0 when empty
- count  output  CW  number of valid entries, registered, range 0..DEPTH
- empty  output  1  count==0
- full  output  1  count==DEPTH
- error  output  1  registered one-cycle pulse flagging an illegal request in the previous cycle
- ovf_err / unf_err  output  1 each  registered one-cycle qualifiers of error: ovf_err = overflow, unf_err = underflow

## Operation
- Storage is stage registers r[0..DEPTH-1].
  - An accepted write shifts every stage: r[0]<=fifo_in, r[k]<=r[k-1].
  - The oldest entry is r[count-1]; fifo_out = r[count-1] when count>0, else 0.
- Request decode per cycle, with W=write and D=delete:
  - Neither: hold all state; count unchanged.
  - W only, not full: shift; count+1.
  - W only, full: overflow; no shift; count unchanged; error=1, ovf_err=1 next cycle.
  - D only, not empty: count-1; stage registers unchanged. Deleted data is not cleared, only invalidated.
  - D only, empty: underflow; no change; error=1, unf_err=1 next cycle.
  - W and D, count>0 (including full): shift; count unchanged. The new oldest is the previous second-oldest.
  - W and D, empty: the write is accepted (shift, count becomes 1) and the delete is rejected as underflow; error=1, unf_err=1 next cycle.
- ovf_err and unf_err are never both 1 in the same cycle.
- error = ovf_err | unf_err.
- count never exceeds DEPTH and never wraps below 0.
- Arithmetic: count updates in CW bits with no truncation, because CW holds DEPTH exactly.

## Timing
- Reset values: all r[k]=0, count=0, empty=1, full=0, error=0, ovf_err=0, unf_err=0, fifo_out=0.
- Reset asserted mid-operation clears all state at the next rising edge; write and delete are ignored in that cycle.
- Write-to-read latency: a word written into an empty FIFO at edge N appears on fifo_out after edge N. It is readable in the same cycle that empty deasserts.
- Flags (count, empty, full) change only at clock edges and are valid the whole cycle after.
- error, ovf_err and unf_err assert in the cycle after the offending request edge and last exactly one cycle per offending request. Consecutive illegal cycles give consecutive pulses.
- Throughput: one write and/or one delete per cycle; no stall cycles.
- fifo_out has combinational delay from the stage registers and count only; there is no path from any input to fifo_out.

## Configuration
- Macro: FIFO_SHIFT_ALMOST_EN.
- Defined:
  - Adds output port almost_full (1 bit), registered.
  - almost_full = (count >= DEPTH-AF_MARGIN).
  - Reset value 0; updates at the same edge as count.
- Undefined:
  - The almost_full port and its logic are absent.
  - AF_MARGIN is ignored.
  - All other behaviour is identical.

## Test plan
- Reset, then write 0x11,0x22,0x33,0x44 (WIDTH=8, DEPTH=4) -> count 1..4, full=1 after the 4th write, fifo_out=0x11 throughout. Then delete x4 -> fifo_out 0x22, 0x33, 0x44, then 0; empty=1.
- From full, write 0x55 -> error=1 and ovf_err=1 for one cycle, count stays 4, fifo_out stays 0x11. Then W+D with 0x66 -> count stays 4, fifo_out=0x22, 0x66 is the newest entry.
- Empty, delete -> error=1 and unf_err=1 for one cycle, count stays 0. Empty, W+D with 0xA5 -> count=1, fifo_out=0xA5, unf_err=1 next cycle.
- Count=2, then reset asserted together with write -> next cycle count=0, empty=1, fifo_out=0, error=0.
- WIDTH=16, DEPTH=7 with FIFO_SHIFT_ALMOST_EN defined and AF_MARGIN=2 -> almost_full rises when count reaches 5 and falls when count drops to 4. Random W/D traffic matches a reference queue model on every cycle, and count never leaves 0..7.
